// File: rtl/systolic_gemm_engine_pkg.sv
// Shared types and default sizing for the systolic GEMM engine.
package systolic_pkg;

  // Job sequencing states of the engine controller.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Default array and datapath sizing.
  localparam int DEF_N        = 4;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_ACC_W    = 32;
  localparam int DEF_K_MAX    = 64;

  // Width of a field able to hold 0..k_max.
  function automatic int k_field_w(input int k_max);
    return $clog2(k_max + 1);
  endfunction

endpackage

// File: rtl/systolic_gemm_engine_if.sv
// Job control, operand stream and result stream of the GEMM engine.
interface systolic_gemm_engine_if #(
  parameter int N        = systolic_pkg::DEF_N,
  parameter int DATA_W   = systolic_pkg::DEF_DATA_W,
  parameter int WEIGHT_W = systolic_pkg::DEF_WEIGHT_W,
  parameter int ACC_W    = systolic_pkg::DEF_ACC_W,
  parameter int K_MAX    = systolic_pkg::DEF_K_MAX
) ();
  import systolic_pkg::*;

  localparam int KW = k_field_w(K_MAX);
  localparam int IW = $clog2(N);

  // Job control
  logic                  start;
  logic [KW-1:0]         k_len;
  logic                  busy;
  logic                  done;

  // Operand stream: one column of A and one row of B per beat
  logic                  in_valid;
  logic                  in_ready;
  logic [N*DATA_W-1:0]   in_a;
  logic [N*WEIGHT_W-1:0] in_b;

  // Result stream: one row of C per beat
  logic                  out_valid;
  logic                  out_ready;
  logic [N*ACC_W-1:0]    out_row;
  logic [IW-1:0]         out_idx;

  modport master (
    output start, k_len, in_valid, in_a, in_b, out_ready,
    input  busy, done, in_ready, out_valid, out_row, out_idx
  );

  modport slave (
    input  start, k_len, in_valid, in_a, in_b, out_ready,
    output busy, done, in_ready, out_valid, out_row, out_idx
  );

endinterface

// File: rtl/systolic_gemm_engine_pe.sv
// One processing element: forwards A right and B down, MACs on aligned valid pairs.
module systolic_pe #(
  parameter int DATA_W   = systolic_pkg::DEF_DATA_W,
  parameter int WEIGHT_W = systolic_pkg::DEF_WEIGHT_W,
  parameter int ACC_W    = systolic_pkg::DEF_ACC_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic [DATA_W-1:0]   i_a,
  input  logic                i_a_valid,
  input  logic [WEIGHT_W-1:0] i_b,
  input  logic                i_b_valid,
  output logic [DATA_W-1:0]   o_a,
  output logic                o_a_valid,
  output logic [WEIGHT_W-1:0] o_b,
  output logic                o_b_valid,
  output logic [ACC_W-1:0]    o_acc
);
  import systolic_pkg::*;

  // Full product width; the accumulator is assumed strictly wider.
  localparam int PW = DATA_W + WEIGHT_W;

  logic signed [PW-1:0] w_prod;
  logic [ACC_W-1:0]     w_prod_ext;
  logic [ACC_W-1:0]     r_acc;
  logic [DATA_W-1:0]    r_a;
  logic                 r_a_valid;
  logic [WEIGHT_W-1:0]  r_b;
  logic                 r_b_valid;

  // Both operands are sign-extended to the product width so the multiply is exact.
  assign w_prod = $signed({{WEIGHT_W{i_a[DATA_W-1]}}, i_a}) *
                  $signed({{DATA_W{i_b[WEIGHT_W-1]}}, i_b});
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};

  // Forwarding registers pass operands and their valid bits one PE onward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_a_valid <= 1'b0;
      r_b       <= '0;
      r_b_valid <= 1'b0;
    end else begin
      r_a       <= i_a;
      r_a_valid <= i_a_valid;
      r_b       <= i_b;
      r_b_valid <= i_b_valid;
    end
  end

  // Accumulate only when the A and B beats arriving this cycle belong together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_a_valid && i_b_valid) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_a       = r_a;
  assign o_a_valid = r_a_valid;
  assign o_b       = r_b;
  assign o_b_valid = r_b_valid;
  assign o_acc     = r_acc;

endmodule

// File: rtl/systolic_gemm_engine.sv
// Output-stationary N x N systolic array computing C = A x B one job at a time.
module systolic_gemm_engine #(
  parameter int N        = systolic_pkg::DEF_N,
  parameter int DATA_W   = systolic_pkg::DEF_DATA_W,
  parameter int WEIGHT_W = systolic_pkg::DEF_WEIGHT_W,
  parameter int ACC_W    = systolic_pkg::DEF_ACC_W,
  parameter int K_MAX    = systolic_pkg::DEF_K_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_gemm_engine_if.slave bus
);
  import systolic_pkg::*;

  localparam int KW = k_field_w(K_MAX);
  localparam int IW = $clog2(N);
  localparam int FW = $clog2(2 * N);
  localparam int SW = DATA_W + WEIGHT_W + 2;

  localparam logic [KW-1:0] K_MAX_L    = KW'(K_MAX);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N - 1);

  // ---------------------------------------------------------------- control
  state_t          r_state;
  state_t          w_state_next;
  logic            w_busy;
  logic            w_in_ready;
  logic            w_out_valid;
  logic [KW-1:0]   r_k_len;
  logic [KW-1:0]   r_beat_cnt;
  logic [FW-1:0]   r_flush_cnt;
  logic [IW-1:0]   r_idx;
  logic            r_done;
  logic            w_start_ok;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_last_beat;
  logic            w_last_row;

  assign w_start_ok  = (r_state == IDLE) && bus.start;
  assign w_in_fire   = bus.in_valid && w_in_ready;
  assign w_out_fire  = bus.out_ready && w_out_valid;
  // r_k_len is never zero while in LOAD, so the subtraction cannot underflow there.
  assign w_last_beat = w_in_fire && (r_beat_cnt == (r_k_len - KW'(1)));
  assign w_last_row  = w_out_fire && (r_idx == IDX_LAST);

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = (bus.k_len == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        w_busy     = 1'b1;
        w_in_ready = 1'b1;
        if (w_last_beat) begin
          w_state_next = FLUSH;
        end
      end
      FLUSH: begin
        w_busy = 1'b1;
        if (r_flush_cnt == FLUSH_LAST) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (w_last_row) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Job length latch, beat/flush/row counters and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_idx       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_last_row;
      if (w_start_ok) begin
        r_k_len    <= (bus.k_len > K_MAX_L) ? K_MAX_L : bus.k_len;
        r_beat_cnt <= '0;
      end else if (w_in_fire) begin
        r_beat_cnt <= r_beat_cnt + KW'(1);
      end
      // The flush lets the last beat cross the whole diagonal (2N-1 cycles).
      if (r_state == FLUSH) begin
        r_flush_cnt <= r_flush_cnt + FW'(1);
      end else begin
        r_flush_cnt <= '0;
      end
      if (w_start_ok) begin
        r_idx <= '0;
      end else if (w_out_fire) begin
        r_idx <= w_last_row ? '0 : (r_idx + IW'(1));
      end
    end
  end

  // ------------------------------------------------------------ skew chains
  // Lane i of A and lane j of B are delayed i (j) cycles so that beat k of
  // A[i] and B[j] meet at PE(i,j) in the same cycle, whatever the bubbles.
  logic [DATA_W-1:0]   w_a_edge   [N];
  logic                w_a_edge_v [N];
  logic [WEIGHT_W-1:0] w_b_edge   [N];
  logic                w_b_edge_v [N];

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_skew
      if (gi == 0) begin : g_direct
        assign w_a_edge[gi]   = bus.in_a[gi*DATA_W +: DATA_W];
        assign w_a_edge_v[gi] = w_in_fire;
        assign w_b_edge[gi]   = bus.in_b[gi*WEIGHT_W +: WEIGHT_W];
        assign w_b_edge_v[gi] = w_in_fire;
      end else begin : g_delay
        logic [DATA_W-1:0]   r_a_dly   [gi];
        logic                r_a_dly_v [gi];
        logic [WEIGHT_W-1:0] r_b_dly   [gi];
        logic                r_b_dly_v [gi];

        // Shift the lane and its valid bit through gi delay stages.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int s = 0; s < gi; s++) begin
              r_a_dly[s]   <= '0;
              r_a_dly_v[s] <= 1'b0;
              r_b_dly[s]   <= '0;
              r_b_dly_v[s] <= 1'b0;
            end
          end else begin
            r_a_dly[0]   <= bus.in_a[gi*DATA_W +: DATA_W];
            r_a_dly_v[0] <= w_in_fire;
            r_b_dly[0]   <= bus.in_b[gi*WEIGHT_W +: WEIGHT_W];
            r_b_dly_v[0] <= w_in_fire;
            for (int s = 1; s < gi; s++) begin
              r_a_dly[s]   <= r_a_dly[s-1];
              r_a_dly_v[s] <= r_a_dly_v[s-1];
              r_b_dly[s]   <= r_b_dly[s-1];
              r_b_dly_v[s] <= r_b_dly_v[s-1];
            end
          end
        end

        assign w_a_edge[gi]   = r_a_dly[gi-1];
        assign w_a_edge_v[gi] = r_a_dly_v[gi-1];
        assign w_b_edge[gi]   = r_b_dly[gi-1];
        assign w_b_edge_v[gi] = r_b_dly_v[gi-1];
      end
    end
  endgenerate

  // -------------------------------------------------------------- PE array
  // Column N of the A mesh and row N of the B mesh are the array's far edges.
  logic [DATA_W-1:0]   w_a   [N][N+1];
  logic                w_av  [N][N+1];
  logic [WEIGHT_W-1:0] w_b   [N+1][N];
  logic                w_bv  [N+1][N];
  logic [ACC_W-1:0]    w_acc [N][N];

  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      assign w_a[gi][0]  = w_a_edge[gi];
      assign w_av[gi][0] = w_a_edge_v[gi];
      assign w_b[0][gi]  = w_b_edge[gi];
      assign w_bv[0][gi] = w_b_edge_v[gi];
      for (gj = 0; gj < N; gj++) begin : g_col
        systolic_pe #(
          .DATA_W   (DATA_W),
          .WEIGHT_W (WEIGHT_W),
          .ACC_W    (ACC_W)
        ) u_pe (
          .clk       (clk),
          .rst_n     (rst_n),
          .i_clear   (w_start_ok),
          .i_a       (w_a[gi][gj]),
          .i_a_valid (w_av[gi][gj]),
          .i_b       (w_b[gi][gj]),
          .i_b_valid (w_bv[gi][gj]),
          .o_a       (w_a[gi][gj+1]),
          .o_a_valid (w_av[gi][gj+1]),
          .o_b       (w_b[gi+1][gj]),
          .o_b_valid (w_bv[gi+1][gj]),
          .o_acc     (w_acc[gi][gj])
        );
      end
    end
  endgenerate

  // Data leaving the far edges of the array has no consumer.
  logic [N*SW-1:0] w_unused_edge_bits;
  logic            w_unused_edge;

  // Collect the far-edge outputs into one vector.
  always_comb begin
    w_unused_edge_bits = '0;
    for (int i = 0; i < N; i++) begin
      w_unused_edge_bits[i*SW +: SW] = {w_a[i][N], w_av[i][N], w_b[N][i], w_bv[N][i]};
    end
  end

  assign w_unused_edge = ^w_unused_edge_bits;

  // ---------------------------------------------------------------- outputs
  logic [N*ACC_W-1:0] w_out_row;

  // Present accumulator row r_idx; it is frozen in DRAIN so a stall holds it.
  always_comb begin
    w_out_row = '0;
    for (int j = 0; j < N; j++) begin
      w_out_row[j*ACC_W +: ACC_W] = w_acc[r_idx][j];
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_row   = w_out_row;
  assign bus.out_idx   = r_idx;

endmodule

// File: tb/tb_systolic_gemm_engine.sv
// Randomised self-checking bench for systolic_gemm_engine against a matrix-product model.
module tb_systolic_gemm_engine;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int WW = 8;
  localparam int AW = 32;
  localparam int KM = 64;
  localparam int KW = $clog2(KM + 1);

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  systolic_gemm_engine_if #(
    .N(N), .DATA_W(DW), .WEIGHT_W(WW), .ACC_W(AW), .K_MAX(KM)
  ) bus ();

  systolic_gemm_engine #(
    .N(N), .DATA_W(DW), .WEIGHT_W(WW), .ACC_W(AW), .K_MAX(KM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Operand matrices and expected product
  int           mat_a [N][KM];
  int           mat_b [KM][N];
  logic [AW-1:0] mat_c [N][N];

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // C = A x B over the first k columns/rows, wrapped to the accumulator width.
  task automatic compute_model(input int k);
    logic signed [63:0] s;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) begin
          s = s + longint'(mat_a[r][kk]) * longint'(mat_b[kk][j]);
        end
        mat_c[r][j] = s[AW-1:0];
      end
    end
  endtask

  task automatic fill_const(input int a, input int b);
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < KM; k++) begin
        mat_a[i][k] = a;
        mat_b[k][i] = b;
      end
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < KM; k++) begin
        mat_a[i][k] = int'($urandom_range(0, 65535)) - 32768;
        mat_b[k][i] = int'($urandom_range(0, 255)) - 128;
      end
    end
  endtask

  // Stream k beats into the engine, optionally with random bubbles carrying junk data.
  task automatic feed_beats(input int k, input int bubbles);
    int  kk;
    int  budget;
    int  tv;
    logic v;
    logic fire;
    kk = 0;
    budget = 0;
    while (kk < k && budget < 2000) begin
      v = (bubbles != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_valid = v;
      for (int i = 0; i < N; i++) begin
        if (v) begin
          tv = mat_a[i][kk];
          bus.in_a[i*DW +: DW] = tv[DW-1:0];
          tv = mat_b[kk][i];
          bus.in_b[i*WW +: WW] = tv[WW-1:0];
        end else begin
          tv = int'($urandom);
          bus.in_a[i*DW +: DW] = tv[DW-1:0];
          bus.in_b[i*WW +: WW] = tv[WW+15:16];
        end
      end
      fire = v && bus.in_ready;
      step();
      if (fire) kk++;
      budget++;
    end
    bus.in_valid = 1'b0;
    if (kk < k) check("load_beats_timeout", kk, k);
  endtask

  // Run one complete job and check flush length, every row, ordering, stall hold and done.
  task automatic run_job(input int job, input int k_req, input int bubbles,
                         input int stall_row, input int stall_len, input int poke);
    int k_eff;
    int cyc;
    int rows;
    int stall;
    int budget;
    logic [N*AW-1:0] held;
    k_eff = (k_req > KM) ? KM : k_req;
    compute_model(k_eff);
    bus.k_len = k_req[KW-1:0];
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    if (k_eff > 0) begin
      check("in_ready_in_load", bus.in_ready, 1);
      feed_beats(k_eff, bubbles);
      check("in_ready_in_flush", bus.in_ready, 0);
      cyc = 0;
      while (!bus.out_valid && cyc < 200) begin
        if (poke != 0 && cyc == 1) begin
          bus.start = 1'b1;
          bus.k_len = KW'(5);
        end else begin
          bus.start = 1'b0;
        end
        step();
        cyc++;
      end
      bus.start = 1'b0;
      check("flush_len", cyc, 2 * N - 1);
    end else begin
      check("kzero_to_drain", bus.out_valid, 1);
    end
    rows = 0;
    stall = 0;
    budget = 0;
    held = '0;
    while (rows < N && budget < 500) begin
      if (!bus.out_valid) begin
        check("out_valid_in_drain", bus.out_valid, 1);
        break;
      end
      if (bus.out_idx == stall_row && stall < stall_len) begin
        if (stall == 0) begin
          held = bus.out_row;
        end else begin
          check("stall_row_hold", (bus.out_row == held), 1);
          check("stall_idx_hold", bus.out_idx, stall_row);
        end
        bus.out_ready = 1'b0;
        stall++;
      end else begin
        bus.out_ready = 1'b1;
        check("row_idx_order", bus.out_idx, rows);
        for (int j = 0; j < N; j++) begin
          check($sformatf("row%0d_lane%0d", rows, j), bus.out_row[j*AW +: AW], mat_c[rows][j]);
        end
        $display("job %0d k=%0d row %0d: %0d %0d %0d %0d", job, k_eff, rows,
                 $signed(bus.out_row[0*AW +: AW]), $signed(bus.out_row[1*AW +: AW]),
                 $signed(bus.out_row[2*AW +: AW]), $signed(bus.out_row[3*AW +: AW]));
        rows++;
      end
      step();
      budget++;
    end
    bus.out_ready = 1'b0;
    if (rows < N) check("drain_rows_timeout", rows, N);
    check("done_pulse", bus.done, 1);
    check("busy_after_job", bus.busy, 0);
    step();
    check("done_one_cycle", bus.done, 0);
    check("no_extra_rows", bus.out_valid, 0);
  endtask

  // Global time bound so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_row", |bus.out_row, 0);
    rst_n = 1'b1;
    step();

    // Identity A, counting B: C rows equal B rows
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < KM; k++) begin
        mat_a[i][k] = (i == k) ? 1 : 0;
        mat_b[k][i] = k * N + i + 1;
      end
    end
    run_job(1, 4, 0, -1, 0, 0);

    // Constant operands, steady and then bubbled input
    fill_const(-1, 127);
    run_job(2, 3, 0, -1, 0, 0);
    run_job(3, 3, 1, -1, 0, 0);

    // Full-depth extremes
    fill_const(32767, 127);
    run_job(4, 64, 0, -1, 0, 0);
    fill_const(-32768, -128);
    run_job(5, 64, 1, -1, 0, 0);

    // Output back-pressure on row 2
    fill_rand();
    run_job(6, 6, 1, 2, 10, 0);

    // Start while busy is ignored, then an empty job yields zero rows
    fill_rand();
    run_job(7, 5, 0, -1, 0, 1);
    fill_rand();
    run_job(8, 0, 0, -1, 0, 0);

    // Reset during FLUSH aborts the job
    fill_rand();
    bus.k_len = KW'(4);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    feed_beats(4, 0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_idx", bus.out_idx, 0);
    check("abort_out_row", |bus.out_row, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("abort_no_done", bus.done, 0);
    end
    rst_n = 1'b1;
    step();
    fill_rand();
    run_job(9, 4, 0, -1, 0, 0);

    // Random jobs, then an over-length request that clamps to K_MAX
    for (int t = 0; t < 4; t++) begin
      fill_rand();
      run_job(10 + t, int'($urandom_range(1, KM)), 1, int'($urandom_range(0, N - 1)),
              int'($urandom_range(0, 4)), 0);
    end
    fill_rand();
    run_job(14, 100, 1, -1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
